// File: rtl/ks_sub11_pipe_pkg.sv
// ============================================================================
// Module : ks_pkg
// Brief  : KGP encoding, default widths and prefix-combine function shared by
//          the Kogge-Stone subtractor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ks_pkg;

    localparam int DEF_W   = 11;
    localparam int DEF_LZW = 4;

    typedef logic [1:0] kgp_t;

    // Both middle codes decode as propagate.
    localparam kgp_t KILL     = 2'b00;
    localparam kgp_t PROP     = 2'b01;
    localparam kgp_t PROP_ALT = 2'b10;
    localparam kgp_t GEN      = 2'b11;

    function automatic kgp_t ks_combine(input kgp_t hi, input kgp_t lo);
        return ((hi == KILL) || (hi == GEN)) ? hi : lo;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ks_sub11_pipe_prefix_cell.sv
// ============================================================================
// Module : ks_prefix_cell
// Brief  : Combines a (hi, lo) KGP pair into one KGP value.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ks_prefix_cell
    import ks_pkg::*;
(
    input  kgp_t hi,
    input  kgp_t lo,
    output kgp_t res
);

    assign res = ks_combine(hi, lo);

endmodule

`default_nettype wire

// File: rtl/ks_sub11_pipe.sv
// ============================================================================
// Module : ks_sub11_pipe
// Brief  : 2-stage Kogge-Stone a-b with borrow, zero and leading-zero count.
//          Define KS_SUB_ABS_DIFF_EN to output |a-b| instead of a-b mod 2^W.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ks_sub11_pipe
    import ks_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int LZW = DEF_LZW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_diff,
    output logic           out_borrow,
    output logic           out_zero,
    output logic [LZW-1:0] out_lzc
);

    // Element 0 is the forced carry-in; element i+1 describes operand bit i.
    localparam int N = W + 1;

    function automatic logic [LZW-1:0] lzc_f(input logic [W-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (v[i]) n = LZW'(W - 1 - i);
        end
        return n;
    endfunction

    logic           s1_valid;
    logic           s1_adv;
    logic           s2_adv;
    logic [W-1:0]   b_n;
    logic [W-1:0]   s1_prop;
    kgp_t           s1_kgp [N];
    kgp_t           k0 [N];
    kgp_t           k1 [N];
    kgp_t           k2 [N];
    kgp_t           k4 [N];
    kgp_t           k8 [N];
    logic [W-1:0]   carry;
    logic [W-1:0]   raw_diff;
    logic [W-1:0]   res_diff;
    logic           borrow_c;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign b_n      = ~in_b;

    assign k0[0] = GEN;
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign k0[i+1] = {in_a[i] & b_n[i], in_a[i] | b_n[i]};
    end

    for (genvar j = 0; j < N; j++) begin : g_d1
        if (j >= 1) begin : g_cell
            ks_prefix_cell u_cell (.hi(k0[j]), .lo(k0[j-1]), .res(k1[j]));
        end else begin : g_pass
            assign k1[j] = k0[j];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_d2
        if (j >= 2) begin : g_cell
            ks_prefix_cell u_cell (.hi(k1[j]), .lo(k1[j-2]), .res(k2[j]));
        end else begin : g_pass
            assign k2[j] = k1[j];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_d4
        if (j >= 4) begin : g_cell
            ks_prefix_cell u_cell (.hi(s1_kgp[j]), .lo(s1_kgp[j-4]), .res(k4[j]));
        end else begin : g_pass
            assign k4[j] = s1_kgp[j];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_d8
        if (j >= 8) begin : g_cell
            ks_prefix_cell u_cell (.hi(k4[j]), .lo(k4[j-8]), .res(k8[j]));
        end else begin : g_pass
            assign k8[j] = k4[j];
        end
    end

    // After the last level every position has resolved to GEN or KILL.
    always_comb begin
        carry = '0;
        for (int i = 0; i < W; i++) begin
            carry[i] = (k8[i] == GEN);
        end
        raw_diff = s1_prop ^ carry;
        borrow_c = (k8[W] != GEN);
`ifdef KS_SUB_ABS_DIFF_EN
        res_diff = borrow_c ? ((~raw_diff) + W'(1)) : raw_diff;
`else
        res_diff = raw_diff;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prop  <= '0;
            for (int j = 0; j < N; j++) begin
                s1_kgp[j] <= KILL;
            end
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_prop <= in_a ^ b_n;
                for (int j = 0; j < N; j++) begin
                    s1_kgp[j] <= k2[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
            out_zero   <= 1'b0;
            out_lzc    <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_diff   <= res_diff;
                out_borrow <= borrow_c;
                out_zero   <= (raw_diff == '0);
                out_lzc    <= lzc_f(res_diff);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ks_sub11_pipe.sv
// ============================================================================
// Module : tb_ks_sub11_pipe
// Brief  : Self-checking bench for ks_sub11_pipe with a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ks_sub11_pipe;

    localparam int W   = 11;
    localparam int LZW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_diff;
    logic           out_borrow;
    logic           out_zero;
    logic [LZW-1:0] out_lzc;

    typedef struct {
        logic [W-1:0]   d;
        logic           br;
        logic           z;
        logic [LZW-1:0] lz;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   npop  = 0;
    logic seen_ov;
    logic seen_ir;
    logic seen_acc;

    always #5 clk = ~clk;

    ks_sub11_pipe #(.W(W), .LZW(LZW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_diff(out_diff), .out_borrow(out_borrow),
        .out_zero(out_zero), .out_lzc(out_lzc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   d;
        int   n;
        d = (a - b) & ((1 << W) - 1);
`ifdef KS_SUB_ABS_DIFF_EN
        if (a < b) d = b - a;
`endif
        n = W;
        for (int t = d; t != 0; t = t >> 1) n--;
        e.d  = W'(d);
        e.br = (a < b);
        e.z  = (a == b);
        e.lz = LZW'(n);
        return e;
    endfunction

    // One cycle: drive inputs, observe at the falling edge, advance past the rising edge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic rdy);
        exp_t e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        @(negedge clk);
        seen_ov  = out_valid;
        seen_ir  = in_ready;
        seen_acc = v && in_ready;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = q[0];
                check("diff",   32'(out_diff),   32'(e.d));
                check("borrow", 32'(out_borrow), 32'(e.br));
                check("zero",   32'(out_zero),   32'(e.z));
                check("lzc",    32'(out_lzc),    32'(e.lz));
                if (rdy) begin
                    void'(q.pop_front());
                    npop++;
                end
            end
        end
        if (v && in_ready) q.push_back(model(int'(a), int'(b)));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) step(1'b0, '0, '0, 1'b1);
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] da [6];
        logic [W-1:0] db [6];
        int           p0;
        da[0] = 11'h400; db[0] = 11'h001;
        da[1] = 11'h001; db[1] = 11'h002;
        da[2] = 11'h155; db[2] = 11'h155;
        da[3] = 11'h000; db[3] = 11'h7FF;
        da[4] = 11'h7FF; db[4] = 11'h000;
        da[5] = 11'h3A5; db[5] = 11'h3A4;

        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_diff",      32'(out_diff),   32'd0);
        check("rst_borrow",    32'(out_borrow), 32'd0);
        check("rst_zero",      32'(out_zero),   32'd0);
        check("rst_lzc",       32'(out_lzc),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed operands with latency check.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, da[i], db[i], 1'b1);
            check("dir_accept", 32'(seen_acc), 32'd1);
            step(1'b0, '0, '0, 1'b1);
            check("lat1_out_valid", 32'(seen_ov), 32'd0);
            step(1'b0, '0, '0, 1'b1);
            check("lat2_out_valid", 32'(seen_ov), 32'd1);
        end
        drain();

        // Backpressure: two accepts fill the pipe, then in_ready must drop.
        p0 = npop;
        step(1'b1, 11'h123, 11'h045, 1'b0);
        step(1'b1, 11'h010, 11'h020, 1'b0);
        check("bp_accept2", 32'(seen_acc), 32'd1);
        step(1'b1, 11'h7F0, 11'h00F, 1'b0);
        check("bp_in_ready_c", 32'(seen_ir), 32'd0);
        step(1'b1, 11'h7F0, 11'h00F, 1'b0);
        check("bp_in_ready_d", 32'(seen_ir), 32'd0);
        check("bp_hold_valid", 32'(seen_ov), 32'd1);
        step(1'b1, 11'h7F0, 11'h00F, 1'b1);
        check("bp_accept3", 32'(seen_acc), 32'd1);
        step(1'b1, 11'h555, 11'h555, 1'b1);
        check("bp_accept4", 32'(seen_acc), 32'd1);
        drain();
        check("bp_count", 32'(npop - p0), 32'd4);

        // Full throughput.
        for (int i = 0; i < 22; i++) begin
            step(1'b1, W'($urandom), W'($urandom), 1'b1);
            check("thru_accept", 32'(seen_acc), 32'd1);
            if (i >= 2) check("thru_out_valid", 32'(seen_ov), 32'd1);
        end
        drain();

        // Reset with two operations in flight.
        step(1'b1, 11'h321, 11'h123, 1'b1);
        step(1'b1, 11'h00A, 11'h0A0, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid),  32'd0);
        check("mid_rst_in_ready",  32'(in_ready),   32'd1);
        check("mid_rst_diff",      32'(out_diff),   32'd0);
        check("mid_rst_borrow",    32'(out_borrow), 32'd0);
        check("mid_rst_zero",      32'(out_zero),   32'd0);
        check("mid_rst_lzc",       32'(out_lzc),    32'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 11'h600, 11'h1FF, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, '0, '0, 1'b1);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, W'($urandom), W'($urandom), ($urandom % 3) != 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
